// File: rtl/usb_fs_pkg.sv
// Shared USB full-speed definitions: IN-arbiter state encodings and the PID
// constants used by the protocol engines.
package usb_fs_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // Token PIDs
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  // Data PIDs
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  // Handshake PIDs
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin picker: first set bit of eligible at or above
// rr_ptr, wrapping modulo N.
module rr_arbiter_pick #(
  parameter int N     = 11,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  int j;

  // Walk offsets from farthest to nearest so the nearest hit wins without a break.
  always_comb begin
    valid = 1'b0;
    index = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      if (eligible[j]) begin
        valid = 1'b1;
        index = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/usb_fs_in_arb.sv
// Packet-granular round-robin arbiter sharing the IN-endpoint write bus of the
// USB FS IN protocol engine among NUM_IN_EPS producers (client i -> endpoint i).
module usb_fs_in_arb
  import usb_fs_pkg::*;
#(
  parameter int NUM_IN_EPS         = 11,
  parameter int MAX_IN_PACKET_SIZE = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_IN_EPS-1:0]     client_req,
  input  logic [8*NUM_IN_EPS-1:0]   client_data,
  input  logic [NUM_IN_EPS-1:0]     client_put,
  input  logic [NUM_IN_EPS-1:0]     client_done,
  output logic [NUM_IN_EPS-1:0]     client_grant,
  output logic [NUM_IN_EPS-1:0]     client_acked,
  input  logic [NUM_IN_EPS-1:0]     in_ep_data_free,
  output logic [NUM_IN_EPS-1:0]     in_ep_data_put,
  output logic [7:0]                in_ep_data,
  output logic [NUM_IN_EPS-1:0]     in_ep_data_done,
  input  logic [NUM_IN_EPS-1:0]     in_ep_acked,
  output logic [5:0]                byte_count
);

  localparam int IDX_W = (NUM_IN_EPS > 1) ? $clog2(NUM_IN_EPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN_EPS - 1);
  localparam logic [5:0]       CNT_MAX  = 6'(MAX_IN_PACKET_SIZE);

  arb_state_t              state, state_nxt;
  logic [NUM_IN_EPS-1:0]   grant_nxt;
  logic [IDX_W-1:0]        gidx, gidx_nxt;
  logic [IDX_W-1:0]        rr_ptr, rr_nxt;
  logic [5:0]              cnt_nxt;

  logic                    pick_valid;
  logic [IDX_W-1:0]        pick_idx;
  logic                    active;
  logic                    fwd_put;
  logic                    fwd_done;

  assign client_acked = in_ep_acked;

  rr_arbiter_pick #(.N(NUM_IN_EPS), .IDX_W(IDX_W)) u_pick (
    .eligible (client_req & in_ep_data_free),
    .rr_ptr   (rr_ptr),
    .valid    (pick_valid),
    .index    (pick_idx)
  );

  // Strobes are suppressed while reset is held so a mid-grant reset forwards nothing.
  assign active   = (state == GRANT) && !reset;
  assign fwd_put  = active && client_put[gidx] && in_ep_data_free[gidx];
  assign fwd_done = active && client_done[gidx];

  always_comb begin
    in_ep_data_put  = '0;
    in_ep_data_done = '0;
    in_ep_data      = 8'h00;
    if (active) begin
      in_ep_data_put[gidx]  = fwd_put;
      in_ep_data_done[gidx] = fwd_done;
      in_ep_data            = client_data[{gidx, 3'b000} +: 8];
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = client_grant;
    gidx_nxt  = gidx;
    rr_nxt    = rr_ptr;
    cnt_nxt   = byte_count;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt           = GRANT;
          grant_nxt           = '0;
          grant_nxt[pick_idx] = 1'b1;
          gidx_nxt            = pick_idx;
          rr_nxt              = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
          cnt_nxt             = '0;
        end
      end
      GRANT: begin
        if (fwd_put && byte_count < CNT_MAX) cnt_nxt = byte_count + 6'd1;
        if (fwd_done || !in_ep_data_free[gidx] || !client_req[gidx] ||
            (fwd_put && cnt_nxt == CNT_MAX)) begin
          state_nxt = RELEASE;
          grant_nxt = '0;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      client_grant <= '0;
      gidx         <= '0;
      rr_ptr       <= '0;
      byte_count   <= '0;
    end else begin
      state        <= state_nxt;
      client_grant <= grant_nxt;
      gidx         <= gidx_nxt;
      rr_ptr       <= rr_nxt;
      byte_count   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_usb_fs_in_arb.sv
// Directed bench for usb_fs_in_arb: forwarded strobes are scored against a
// queue of expected bus events filled as stimulus is driven.
module tb_usb_fs_in_arb;
  import usb_fs_pkg::*;

  localparam int N = 11;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    client_req = '0;
  logic [8*N-1:0]  client_data = '0;
  logic [N-1:0]    client_put = '0;
  logic [N-1:0]    client_done = '0;
  logic [N-1:0]    client_grant;
  logic [N-1:0]    client_acked;
  logic [N-1:0]    in_ep_data_free = '1;
  logic [N-1:0]    in_ep_data_put;
  logic [7:0]      in_ep_data;
  logic [N-1:0]    in_ep_data_done;
  logic [N-1:0]    in_ep_acked = '0;
  logic [5:0]      byte_count;

  typedef struct {
    logic [N-1:0] put;
    logic [7:0]   data;
    logic [N-1:0] done;
  } ev_t;

  ev_t sb[$];
  int  passed = 0;
  int  total  = 0;

  usb_fs_in_arb #(.NUM_IN_EPS(N), .MAX_IN_PACKET_SIZE(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .client_req      (client_req),
    .client_data     (client_data),
    .client_put      (client_put),
    .client_done     (client_done),
    .client_grant    (client_grant),
    .client_acked    (client_acked),
    .in_ep_data_free (in_ep_data_free),
    .in_ep_data_put  (in_ep_data_put),
    .in_ep_data      (in_ep_data),
    .in_ep_data_done (in_ep_data_done),
    .in_ep_acked     (in_ep_acked),
    .byte_count      (byte_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) passed++;
    else $error("FAIL %s actual=%0h expected=%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int c, input logic [7:0] v);
    client_data[c*8 +: 8] = v;
  endtask

  task automatic expect_ev(input logic [N-1:0] p, input logic [7:0] d, input logic [N-1:0] dn);
    ev_t e;
    e.put  = p;
    e.data = d;
    e.done = dn;
    sb.push_back(e);
  endtask

  // Every forwarded strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (|in_ep_data_put || |in_ep_data_done) begin
      if (sb.size() == 0) begin
        check("unexpected_put", 32'(in_ep_data_put), 32'(0));
        check("unexpected_done", 32'(in_ep_data_done), 32'(0));
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("sb_put", 32'(in_ep_data_put), 32'(e.put));
        check("sb_done", 32'(in_ep_data_done), 32'(e.done));
        if (|e.put) check("sb_data", 32'(in_ep_data), 32'(e.data));
      end
    end
  end

  initial begin
    int order[4];
    order = '{0, 3, 7, 0};

    // Reset state
    tick();
    tick();
    check("rst_grant", 32'(client_grant), 32'(0));
    check("rst_count", 32'(byte_count), 32'(0));
    check("rst_data", 32'(in_ep_data), 32'(0));
    check("rst_put", 32'(in_ep_data_put), 32'(0));
    reset = 1'b0;
    tick();
    check("idle_grant", 32'(client_grant), 32'(0));

    // Single client, 5 bytes then done
    client_req[2] = 1'b1;
    tick();
    check("t1_grant", 32'(client_grant), 32'(1 << 2));
    for (int k = 0; k < 5; k++) begin
      set_data(2, 8'hA0 + 8'(k));
      client_put[2] = 1'b1;
      expect_ev(N'(1 << 2), 8'hA0 + 8'(k), '0);
      tick();
    end
    client_put[2]  = 1'b0;
    client_done[2] = 1'b1;
    expect_ev('0, 8'h00, N'(1 << 2));
    tick();
    client_done[2] = 1'b0;
    client_req[2]  = 1'b0;
    check("t1_rel_grant", 32'(client_grant), 32'(0));
    check("t1_count", 32'(byte_count), 32'(5));
    check("t1_rel_state", 32'(dut.state), 32'(RELEASE));
    tick();
    check("t1_idle_state", 32'(dut.state), 32'(IDLE));

    // Round robin from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    client_req[0] = 1'b1;
    client_req[3] = 1'b1;
    client_req[7] = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t2_grant", 32'(client_grant), 32'(1 << order[i]));
      set_data(order[i], 8'h30 + 8'(i));
      client_put[order[i]]  = 1'b1;
      client_done[order[i]] = 1'b1;
      expect_ev(N'(1 << order[i]), 8'h30 + 8'(i), N'(1 << order[i]));
      tick();
      client_put  = '0;
      client_done = '0;
      if (i == 3) client_req = '0;
      check("t2_release", 32'(client_grant), 32'(0));
      tick();
      check("t2_idle", 32'(client_grant), 32'(0));
      if (i < 3) tick();
    end

    // Buffer full: release after 32 bytes, 33rd dropped
    client_req[1] = 1'b1;
    tick();
    check("t3_grant", 32'(client_grant), 32'(1 << 1));
    for (int k = 0; k < 32; k++) begin
      set_data(1, 8'h40 + 8'(k));
      client_put[1] = 1'b1;
      expect_ev(N'(1 << 1), 8'h40 + 8'(k), '0);
      tick();
    end
    check("t3_rel_grant", 32'(client_grant), 32'(0));
    check("t3_count", 32'(byte_count), 32'(32));
    set_data(1, 8'hEE);
    tick();
    client_put[1] = 1'b0;
    client_req[1] = 1'b0;
    check("t3_idle_grant", 32'(client_grant), 32'(0));
    tick();

    // Stalled endpoint is skipped until its buffer frees
    in_ep_data_free[4] = 1'b0;
    client_req[4] = 1'b1;
    client_req[5] = 1'b1;
    tick();
    check("t4_grant5", 32'(client_grant), 32'(1 << 5));
    client_done[5] = 1'b1;
    expect_ev('0, 8'h00, N'(1 << 5));
    tick();
    client_done[5] = 1'b0;
    client_req[5]  = 1'b0;
    check("t4_release", 32'(client_grant), 32'(0));
    tick();
    tick();
    check("t4_stall_hold", 32'(client_grant), 32'(0));
    in_ep_data_free[4] = 1'b1;
    tick();
    check("t4_grant4", 32'(client_grant), 32'(1 << 4));
    client_done[4] = 1'b1;
    expect_ev('0, 8'h00, N'(1 << 4));
    tick();
    client_done[4] = 1'b0;
    client_req[4]  = 1'b0;
    tick();
    tick();

    // Ungranted strobe is dropped; acked passes through
    client_req[2] = 1'b1;
    tick();
    check("t5_grant", 32'(client_grant), 32'(1 << 2));
    set_data(2, 8'h22);
    set_data(6, 8'h66);
    client_put[6] = 1'b1;
    in_ep_acked = 11'h5A5;
    #1;
    check("t5_put6", 32'(in_ep_data_put), 32'(0));
    check("t5_data", 32'(in_ep_data), 32'(8'h22));
    check("t5_acked", 32'(client_acked), 32'(11'h5A5));
    tick();
    client_put[6] = 1'b0;
    in_ep_acked = '0;
    check("t5_hold", 32'(client_grant), 32'(1 << 2));
    set_data(2, 8'h23);
    client_put[2] = 1'b1;
    expect_ev(N'(1 << 2), 8'h23, '0);
    tick();
    client_put[2]  = 1'b0;
    client_done[2] = 1'b1;
    expect_ev('0, 8'h00, N'(1 << 2));
    tick();
    client_done[2] = 1'b0;
    client_req[2]  = 1'b0;
    tick();
    tick();

    // Reset while granted after 3 bytes
    client_req[3] = 1'b1;
    tick();
    check("t6_grant", 32'(client_grant), 32'(1 << 3));
    for (int k = 0; k < 3; k++) begin
      set_data(3, 8'h60 + 8'(k));
      client_put[3] = 1'b1;
      expect_ev(N'(1 << 3), 8'h60 + 8'(k), '0);
      tick();
    end
    check("t6_count3", 32'(byte_count), 32'(3));
    reset = 1'b1;
    tick();
    check("t6_grant0", 32'(client_grant), 32'(0));
    check("t6_count0", 32'(byte_count), 32'(0));
    check("t6_state", 32'(dut.state), 32'(IDLE));
    check("t6_rr_ptr", 32'(dut.rr_ptr), 32'(0));
    reset = 1'b0;
    client_put[3] = 1'b0;
    client_req[3] = 1'b0;
    tick();

    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
